if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC register, the single-outstanding instruction-memory request/response handshake and the IF/ID pipeline register. It sits directly upstream of the hazard detection unit and decode. It consumes that unit's stall/flush controls (`pc_wren`, `IFID_wren`, `IFID_clear`) and the EX-stage branch redirect, and presents `{pc, pc+4, instr, valid}` to ID.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `pc_wren_i` in 1: PC may advance (hazard unit).
- `IFID_wren_i` in 1: IF/ID may load (hazard unit).
- `IFID_clear_i` in 1: IF/ID loads a bubble (hazard unit).
- `br_flush_i` in 1: redirect fetch to `br_target_i`.
- `br_target_i` in 32: redirect PC; bits [1:0] ignored and treated as 0.
- `imem_req_o` out 1: fetch request valid.
- `imem_addr_o` out 32: fetch address, word aligned.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response valid; at most one outstanding, at least 1 cycle after grant.
- `imem_rdata_i` in 32: instruction word.
- `IFID_pc_o` out 32, `IFID_pc4_o` out 32, `IFID_instr_o` out 32, `IFID_valid_o` out 1: IF/ID register contents.

## Operation
- `deliver` = `pc_wren_i & IFID_wren_i & ~IFID_clear_i & ~br_flush_i`.
- FSM states: FETCH, WAIT, HOLD, KILL. Reset → FETCH, `pc_q` = `RESET_PC`.
- FETCH: `imem_req_o = ~br_flush_i`, `imem_addr_o = pc_q`.
  - Flush → `pc_q` ← target, stay.
  - Grant → WAIT.
- WAIT, with `rvalid`:
  - `deliver` → load IF/ID with `{pc_q, pc_q+4, rdata, 1}`; `pc_q` ← `pc_q+4`. Back-to-back: same cycle assert `imem_req_o` with `addr = pc_q+4`; grant → WAIT, else FETCH.
  - Flush → drop rdata, `pc_q` ← target, FETCH.
  - Otherwise (stall) → capture rdata in the hold buffer, HOLD.
- WAIT, no `rvalid`:
  - Flush → `pc_q` ← target, KILL.
  - Otherwise stay.
- HOLD: no request.
  - Flush → drop buffer, `pc_q` ← target, FETCH.
  - `deliver` → load IF/ID from buffer, `pc_q` ← `pc_q+4`, FETCH.
- KILL: no request. Flush → `pc_q` ← newest target. `rvalid` → discard data, FETCH.
- IF/ID register, priority high→low:
  1. reset or `IFID_clear_i` → bubble.
  2. `IFID_wren_i=0` → hold.
  3. `deliver` with data → load.
  4. Otherwise → bubble.
- Bubble = `instr` `NOP` (`32'h0000_0013`), `valid` 0, pc fields 0.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC + 4` wraps to 0.

## Timing
- Reset values:
  - `imem_req_o` 1 (FETCH).
  - `imem_addr_o` = `RESET_PC`.
  - `IFID_*` = bubble.
- Latency: IF/ID loads on the edge ending the cycle in which `rvalid & deliver`. With a 1-cycle-latency, always-granting memory, sustained throughput is 1 instruction/cycle. First valid IF/ID appears 2 cycles after reset deasserts.
- Redirect: first request to the target issues the cycle after `br_flush_i`. Exception: in KILL, the request issues the cycle after the stale response.
- Flush and stall in the same cycle: flush wins.
- `imem_req_o` is never asserted while a response is outstanding, except in the back-to-back case, where the current response is consumed in the same cycle.
- `rst_i` mid-transaction: state → FETCH, PC → `RESET_PC`. The environment guarantees imem is reset together with this block, so no stale `rvalid` arrives after reset.

## Structure
- Shared package `if_pkg`:
  - `NOP_INSTR` constant.
  - `if_state_e` enum.
  - `ifid_t` struct `{pc, pc4, instr, valid}`.
- One natural sub-module, `ifid_reg`: the IF/ID register with clear-over-enable priority and the bubble value. The FSM, PC and hold buffer stay in `if_stage`.

## Test plan
- Reset, memory always grants with 1-cycle `rvalid`, no stalls → IF/ID `pc` = 0, 4, 8, 12 on consecutive cycles, `valid` = 1, first valid 2 cycles after reset.
- `IFID_wren_i = pc_wren_i = 0` for 3 cycles while the response for `pc 0x10` arrives → HOLD, no request. IF/ID unchanged. On release, IF/ID = `{0x10, 0x14, data}`, next request addresses `0x14`.
- `br_flush_i` with target `0x200` while in WAIT, no `rvalid` → KILL. Stale response discarded. Next request addresses `0x200`, and IF/ID shows a bubble until it returns.
- Flush and stall asserted together while in HOLD → buffer dropped, `pc_q = target`, IF/ID = bubble (`IFID_clear_i`).
- Memory withholds grant for 4 cycles → `imem_req_o` and `imem_addr_o` stable, IF/ID bubbles, then normal delivery.
- PC at `32'hFFFF_FFFC` delivered → next request addresses 0; `rst_i` mid-WAIT → next-cycle request at `RESET_PC`.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   NOP_INSTR  : bubble instruction (addi x0, x0, 0)
//   if_state_e : fetch FSM states
//   ifid_t     : IF/ID pipeline register payload
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch,  // issue request for pc_q
    StWait,   // request granted, waiting for rvalid
    StHold,   // response captured while ID was stalled
    StKill    // redirect arrived while a response is in flight; drop it
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.pc    = '0;
    b.pc4   = '0;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus.
//   req/addr : fetch request and word-aligned address (master drives)
//   gnt      : request accepted this cycle (slave drives)
//   rvalid   : response valid, at most one outstanding (slave drives)
//   rdata    : instruction word (slave drives)
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register.
//   clk_i/rst_i : clock, synchronous active-high reset
//   clear_i     : load a bubble (highest priority after reset)
//   wren_i      : register may change; low holds contents
//   load_i      : data_i is a deliverable instruction; otherwise a bubble is loaded
//   data_i      : payload to load
//   ifid_o      : register contents
module ifid_reg
  import if_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clear_i,
  input  logic  wren_i,
  input  logic  load_i,
  input  ifid_t data_i,
  output ifid_t ifid_o
);

  ifid_t ifid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ifid_q <= ifid_bubble();
    end else if (wren_i) begin
      ifid_q <= load_i ? data_i : ifid_bubble();
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake, IF/ID register.
//   clk_i/rst_i     : clock, synchronous active-high reset
//   pc_wren_i       : PC may advance
//   IFID_wren_i     : IF/ID may load
//   IFID_clear_i    : IF/ID loads a bubble
//   br_flush_i      : redirect fetch to br_target_i (bits [1:0] ignored)
//   imem_io         : instruction-memory bus (master side)
//   IFID_*_o        : IF/ID register contents presented to decode
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         pc_wren_i,
  input  logic         IFID_wren_i,
  input  logic         IFID_clear_i,
  input  logic         br_flush_i,
  input  logic [31:0]  br_target_i,
  if_stage_if.master   imem_io,
  output logic [31:0]  IFID_pc_o,
  output logic [31:0]  IFID_pc4_o,
  output logic [31:0]  IFID_instr_o,
  output logic         IFID_valid_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;

  logic        deliver;
  logic        load;
  ifid_t       load_data;
  ifid_t       ifid;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign deliver  = pc_wren_i & IFID_wren_i & ~IFID_clear_i & ~br_flush_i;
  assign pc_plus4 = pc_q + 32'd4;
  assign target   = {br_target_i[31:2], 2'b00};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    hold_d          = hold_q;
    imem_io.req     = 1'b0;
    imem_io.addr    = pc_q;
    load            = 1'b0;
    load_data.pc    = pc_q;
    load_data.pc4   = pc_plus4;
    load_data.instr = imem_io.rdata;
    load_data.valid = 1'b1;

    unique case (state_q)
      StFetch: begin
        imem_io.req = ~br_flush_i;
        if (br_flush_i) begin
          pc_d = target;
        end else if (imem_io.gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_io.rvalid) begin
          if (deliver) begin
            // Back-to-back: consume this response and request the next word together.
            load         = 1'b1;
            pc_d         = pc_plus4;
            imem_io.req  = 1'b1;
            imem_io.addr = pc_plus4;
            state_d      = imem_io.gnt ? StWait : StFetch;
          end else if (br_flush_i) begin
            pc_d    = target;
            state_d = StFetch;
          end else begin
            hold_d  = imem_io.rdata;
            state_d = StHold;
          end
        end else if (br_flush_i) begin
          pc_d    = target;
          state_d = StKill;
        end
      end
      StHold: begin
        if (br_flush_i) begin
          pc_d    = target;
          state_d = StFetch;
        end else if (deliver) begin
          load            = 1'b1;
          load_data.instr = hold_q;
          pc_d            = pc_plus4;
          state_d         = StFetch;
        end
      end
      StKill: begin
        if (br_flush_i) begin
          pc_d = target;
        end
        if (imem_io.rvalid) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  ifid_reg u_ifid_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (IFID_clear_i),
    .wren_i  (IFID_wren_i),
    .load_i  (load),
    .data_i  (load_data),
    .ifid_o  (ifid)
  );

  assign IFID_pc_o    = ifid.pc;
  assign IFID_pc4_o   = ifid.pc4;
  assign IFID_instr_o = ifid.instr;
  assign IFID_valid_o = ifid.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small instruction-memory model.
// Memory returns ~addr as the instruction word, rvalid `lat` cycles after grant.
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_wren, ifid_wren, ifid_clear, br_flush;
  logic [31:0] br_target;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
  logic        ifid_valid;

  logic        gnt_en;
  int unsigned lat;
  logic        pend;
  int unsigned cnt;
  logic [31:0] paddr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_stage_if imem_bus ();

  assign imem_bus.gnt    = gnt_en & imem_bus.req;
  assign imem_bus.rvalid = pend && (cnt == 1);
  assign imem_bus.rdata  = ~paddr;

  always @(posedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= '0;
    end else begin
      if (imem_bus.rvalid) pend <= 1'b0;
      else if (pend) cnt <= cnt - 1;
      if (imem_bus.req && imem_bus.gnt) begin
        pend  <= 1'b1;
        cnt   <= lat;
        paddr <= imem_bus.addr;
      end
    end
  end

  if_stage dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_wren_i    (pc_wren),
    .IFID_wren_i  (ifid_wren),
    .IFID_clear_i (ifid_clear),
    .br_flush_i   (br_flush),
    .br_target_i  (br_target),
    .imem_io      (imem_bus),
    .IFID_pc_o    (ifid_pc),
    .IFID_pc4_o   (ifid_pc4),
    .IFID_instr_o (ifid_instr),
    .IFID_valid_o (ifid_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid);
    chk({tag, ".pc"}, ifid_pc, pc);
    chk({tag, ".pc4"}, ifid_pc4, valid ? pc + 32'd4 : 32'd0);
    chk({tag, ".instr"}, ifid_instr, instr);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
  endtask

  task automatic set_ctl(input logic pw, input logic iw, input logic cl, input logic fl,
                         input logic [31:0] tgt);
    pc_wren    = pw;
    ifid_wren  = iw;
    ifid_clear = cl;
    br_flush   = fl;
    br_target  = tgt;
  endtask

  initial begin
    rst    = 1'b1;
    gnt_en = 1'b1;
    lat    = 1;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

    // Reset state
    step(); step();
    chk("rst.req", {31'd0, imem_bus.req}, 32'd1);
    chk("rst.addr", imem_bus.addr, 32'h0);
    chk_ifid("rst.ifid", 32'd0, NOP_INSTR, 1'b0);

    // Streaming, 1-cycle memory, no stalls
    rst = 1'b0;
    step();  // E1
    chk("stream.first_bubble", {31'd0, ifid_valid}, 32'd0);
    step();  // E2
    chk_ifid("stream0", 32'h0, ~32'h0, 1'b1);
    step();
    chk_ifid("stream4", 32'h4, ~32'h4, 1'b1);
    step();
    chk_ifid("stream8", 32'h8, ~32'h8, 1'b1);
    step();  // E5
    chk_ifid("stream12", 32'hC, ~32'hC, 1'b1);

    // Stall 3 cycles while response for 0x10 arrives
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    chk("stall.req_c6", {31'd0, imem_bus.req}, 32'd0);
    step();
    chk("stall.req_e6", {31'd0, imem_bus.req}, 32'd0);
    chk_ifid("stall.hold_e6", 32'hC, ~32'hC, 1'b1);
    step();
    chk("stall.req_e7", {31'd0, imem_bus.req}, 32'd0);
    step();  // E8
    chk_ifid("stall.hold_e8", 32'hC, ~32'hC, 1'b1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    settle();
    chk("release.req_c9", {31'd0, imem_bus.req}, 32'd0);
    step();  // E9
    chk_ifid("release", 32'h10, ~32'h10, 1'b1);
    chk("release.req", {31'd0, imem_bus.req}, 32'd1);
    chk("release.addr", imem_bus.addr, 32'h14);

    // Flush while WAIT with response outstanding -> KILL
    lat = 3;
    step();  // E10: granted 0x14
    chk("kill.wait_req", {31'd0, imem_bus.req}, 32'd0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0201);
    step();  // E11
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    settle();
    chk("kill.req_c12", {31'd0, imem_bus.req}, 32'd0);
    chk("kill.ifid_c12", {31'd0, ifid_valid}, 32'd0);
    step();  // E12
    chk("kill.req_c13", {31'd0, imem_bus.req}, 32'd0);
    step();  // E13: stale response consumed
    chk_ifid("kill.discard", 32'd0, NOP_INSTR, 1'b0);
    chk("kill.req_c14", {31'd0, imem_bus.req}, 32'd1);
    chk("kill.addr_c14", imem_bus.addr, 32'h200);
    lat = 1;
    step();  // E14
    chk("kill.bubble_e14", {31'd0, ifid_valid}, 32'd0);
    step();  // E15
    chk_ifid("kill.target", 32'h200, ~32'h200, 1'b1);

    // Stall in WAIT -> HOLD, then flush+clear+stall together
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();  // E16: HOLD with 0x204
    chk_ifid("hold.keep", 32'h200, ~32'h200, 1'b1);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    settle();
    chk("hold_flush.req", {31'd0, imem_bus.req}, 32'd0);
    step();  // E17
    chk_ifid("hold_flush.bubble", 32'd0, NOP_INSTR, 1'b0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

    // Grant withheld 4 cycles
    gnt_en = 1'b0;
    settle();
    chk("nogrant.req0", {31'd0, imem_bus.req}, 32'd1);
    chk("nogrant.addr0", imem_bus.addr, 32'h300);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("nogrant.req%0d", i), {31'd0, imem_bus.req}, 32'd1);
      chk($sformatf("nogrant.addr%0d", i), imem_bus.addr, 32'h300);
      chk($sformatf("nogrant.valid%0d", i), {31'd0, ifid_valid}, 32'd0);
    end
    step();  // E21
    gnt_en = 1'b1;
    step();  // E22
    chk("nogrant.valid_e22", {31'd0, ifid_valid}, 32'd0);
    step();  // E23
    chk_ifid("nogrant.deliver", 32'h300, ~32'h300, 1'b1);
    step();  // E24
    chk_ifid("nogrant.next", 32'h304, ~32'h304, 1'b1);

    // Redirect to top of address space, check wrap
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step();  // E25: response for 0x308 dropped
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap.flush_bubble", {31'd0, ifid_valid}, 32'd0);
    settle();
    chk("wrap.addr_top", imem_bus.addr, 32'hFFFF_FFFC);
    chk("wrap.req_top", {31'd0, imem_bus.req}, 32'd1);
    step();  // E26
    lat = 3;
    settle();
    chk("wrap.addr_zero", imem_bus.addr, 32'h0);
    chk("wrap.req_zero", {31'd0, imem_bus.req}, 32'd1);
    step();  // E27
    chk("wrap.ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap.ifid_pc4", ifid_pc4, 32'h0);
    chk("wrap.ifid_instr", ifid_instr, 32'h3);

    // Reset mid-WAIT
    chk("midrst.wait_req", {31'd0, imem_bus.req}, 32'd0);
    rst = 1'b1;
    step();  // E28
    rst = 1'b0;
    lat = 1;
    settle();
    chk("midrst.req", {31'd0, imem_bus.req}, 32'd1);
    chk("midrst.addr", imem_bus.addr, 32'h0);
    chk_ifid("midrst.ifid", 32'd0, NOP_INSTR, 1'b0);
    step();
    step();
    chk_ifid("midrst.restart", 32'h0, ~32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
